pi1r_rrarb: RTL and testbench
=============================

// Module: pi1r_rrarb
// PURPOSE
//  Round-robin arbiter sharing one pi1 master port (e.g. a PerInt master slot) among
//  MASTERCOUNT pi1 requesters (multipu, DMA, debug). Grants one requester at a time,
//  muxes its op/addr/data/sel onto the shared port and routes rdy back to it only.
//  Bounds grant tenure with a burst counter so no requester starves the others.
// PARAMETERS
//  ARCHBITSZ    32  data width; ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8), SELBITSZ = ARCHBITSZ/8
//  MASTERCOUNT  4   number of requesters, 2..16
//  BURSTMAX     8   max ops accepted per grant before forced rotation, 1..255
// PORTS
//  clk_i      in   1                      single clock (the PerInt clock)
//  rst_i      in   1                      reset, synchronous, active-low
//  m_op_i     in   2*MASTERCOUNT          per-requester op (0 NOOP,1 WR,2 RD,3 RDWR); idx i at [2*i+:2]
//  m_addr_i   in   ADDRBITSZ*MASTERCOUNT  per-requester word address
//  m_data_i   in   ARCHBITSZ*MASTERCOUNT  per-requester write data
//  m_sel_i    in   SELBITSZ*MASTERCOUNT   per-requester byte select
//  m_data_o   out  ARCHBITSZ              read data, broadcast to all requesters (= s_data_i)
//  m_rdy_o    out  MASTERCOUNT            per-requester rdy; only granted bit may be 1
//  s_op_o     out  2                      shared-port op
//  s_addr_o   out  ADDRBITSZ              shared-port address
//  s_data_o   out  ARCHBITSZ              shared-port write data
//  s_sel_o    out  SELBITSZ               shared-port byte select
//  s_data_i   in   ARCHBITSZ              shared-port read data
//  s_rdy_i    in   1                      shared-port rdy
//  gnt_o      out  MASTERCOUNT            one-hot current grant (0 when none)
// BEHAVIOUR
//  - pi1 rules: op accepted at posedge where op!=NOOP and rdy=1; RD/RDWR data valid on
//    data at the next posedge where rdy=1 (may coincide with next op's acceptance).
//  - Reset (rst_i==0 at posedge): state IDLE, gnt_o=0, m_rdy_o=0, s_op_o=NOOP,
//    last-granted pointer=MASTERCOUNT-1, burst count=0. s_addr/data/sel_o=0.
//  - States: IDLE, GRANT, DRAIN.
//  - IDLE: s_op_o=NOOP, m_rdy_o=0. If any m_op_i!=NOOP, pick first requesting index
//    strictly after last-granted pointer (wrapping), register it: next cycle GRANT,
//    gnt_o one-hot, count=0. Arbitration latency 1 cycle; no request -> stay IDLE.
//  - GRANT (index g): s_* = m_*[g] combinationally; m_rdy_o[g]=s_rdy_i, others 0.
//    On acceptance count++. Leave to DRAIN when: acceptance with count+1==BURSTMAX, or
//    s_rdy_i=1 with m_op_i[g]==NOOP (requester idle; delivers any pending read data).
//  - DRAIN: s_op_o forced NOOP, addr/data/sel still from g; m_rdy_o[g]=s_rdy_i.
//    First posedge with s_rdy_i=1 completes outstanding read return; then pointer=g,
//    gnt_o=0, state IDLE. Requester g sees rdy only as read completion, never acceptance.
//  - Pointer updates only on release, so g is lowest priority at the next arbitration.
//  - A requester dropping its op while s_rdy_i=0 in GRANT is a protocol error; arbiter
//    simply presents NOOP and waits for s_rdy_i (no hang, no spurious accept).
//  - Non-granted requesters may change op freely; they see m_rdy_o=0 and are never muxed.
//  - Reset mid-transaction: abandoned immediately; next cycle IDLE with reset values.
//  - BURSTMAX=1: every accepted op goes straight to DRAIN.
// TESTING
//  1 Reset: hold rst_i=0 3 cycles with all ops RD -> gnt_o=0, m_rdy_o=0, s_op_o=0.
//  2 Single: m0 RD addr 0x400, s_rdy_i=1, s_data_i=0xDEADBEEF -> gnt_o=0001 after 1 cycle,
//    m_rdy_o[0]=1, m0 gets 0xDEADBEEF, then m0 NOOP -> DRAIN -> IDLE, gnt_o=0.
//  3 Round robin: m0..m3 all continuous WR, BURSTMAX=8, s_rdy_i=1 -> grant order
//    m0,m1,m2,m3,m0; exactly 8 accepts per grant; rdy never to 2 requesters at once.
//  4 Backpressure: m2 RD, s_rdy_i low 5 cycles -> s_op_o=RD held, no count++; release
//    only after accept + data cycle; read data matches.
//  5 Fairness: m1 continuous, m3 single WR arrives mid-burst -> m3 granted right after
//    m1's 8th accept completes DRAIN; m1 regranted after m3.
//  6 Reset during DRAIN with read outstanding -> next cycle IDLE, gnt_o=0, pointer=3.

Source files
------------

// File: rtl/pi1r_rrarb_if.sv
// Signal bundle between the requesters, the round-robin arbiter and the shared pi1 port.
// The arbiter uses the slave modport; the requester/shared-port side uses master.
interface pi1r_rrarb_if #(
  parameter int ARCHBITSZ   = 32,
  parameter int MASTERCOUNT = 4
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
  localparam int SELBITSZ  = ARCHBITSZ / 8;

  logic [2*MASTERCOUNT-1:0]         m_op_i;
  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i;
  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i;
  logic [ARCHBITSZ-1:0]             m_data_o;
  logic [MASTERCOUNT-1:0]           m_rdy_o;
  logic [1:0]                       s_op_o;
  logic [ADDRBITSZ-1:0]             s_addr_o;
  logic [ARCHBITSZ-1:0]             s_data_o;
  logic [SELBITSZ-1:0]              s_sel_o;
  logic [ARCHBITSZ-1:0]             s_data_i;
  logic                             s_rdy_i;
  logic [MASTERCOUNT-1:0]           gnt_o;

  modport slave (
    input  m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
    output m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o, gnt_o
  );

  modport master (
    output m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
    input  m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o, gnt_o
  );
endinterface

// File: rtl/pi1r_rrarb.sv
// Round-robin arbiter sharing one pi1 master port among MASTERCOUNT requesters,
// with grant tenure bounded by a burst down-counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   ST_IDLE  | no owner; pick next requester strictly after the last-granted one
//   ST_GRANT | owner muxed onto the shared port; accepts counted down from BURSTMAX
//   ST_DRAIN | shared op forced NOOP; wait one s_rdy_i for read return, then release
module pi1r_rrarb #(
  parameter int ARCHBITSZ   = 32,
  parameter int MASTERCOUNT = 4,
  parameter int BURSTMAX    = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  pi1r_rrarb_if.slave   bus
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int IDXW      = $clog2(MASTERCOUNT);

  localparam logic [1:0]             OP_NOOP  = 2'd0;
  localparam logic [7:0]             BURST_LD = 8'(BURSTMAX);
  localparam logic [MASTERCOUNT-1:0] GNT_ONE  = MASTERCOUNT'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN
  } state_t;

  state_t                 state_q;
  logic [IDXW-1:0]        idx_q;
  logic [IDXW-1:0]        ptr_q;
  logic [MASTERCOUNT-1:0] gnt_q;
  logic [7:0]             burst_left_q;

  logic                   pick_vld;
  logic [IDXW-1:0]        pick_idx;
  int                     scan_j;

  logic [1:0]             g_op;
  logic [ADDRBITSZ-1:0]   g_addr;
  logic [ARCHBITSZ-1:0]   g_data;
  logic [SELBITSZ-1:0]    g_sel;
  logic                   accept;

  // Scan starts one past the pointer, so the last owner is checked last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_j   = 0;
    for (int k = 1; k <= MASTERCOUNT; k++) begin
      scan_j = int'(ptr_q) + k;
      if (scan_j >= MASTERCOUNT) scan_j = scan_j - MASTERCOUNT;
      if (!pick_vld && (bus.m_op_i[2*scan_j +: 2] != OP_NOOP)) begin
        pick_vld = 1'b1;
        pick_idx = IDXW'(scan_j);
      end
    end
  end

  always_comb begin
    g_op   = bus.m_op_i[2*int'(idx_q) +: 2];
    g_addr = bus.m_addr_i[ADDRBITSZ*int'(idx_q) +: ADDRBITSZ];
    g_data = bus.m_data_i[ARCHBITSZ*int'(idx_q) +: ARCHBITSZ];
    g_sel  = bus.m_sel_i[SELBITSZ*int'(idx_q) +: SELBITSZ];
    accept = (state_q == ST_GRANT) && (g_op != OP_NOOP) && bus.s_rdy_i;
  end

  always_comb begin
    bus.s_op_o   = (state_q == ST_GRANT) ? g_op : OP_NOOP;
    bus.s_addr_o = (state_q != ST_IDLE) ? g_addr : '0;
    bus.s_data_o = (state_q != ST_IDLE) ? g_data : '0;
    bus.s_sel_o  = (state_q != ST_IDLE) ? g_sel : '0;
    bus.m_rdy_o  = gnt_q & {MASTERCOUNT{bus.s_rdy_i}};
    bus.m_data_o = bus.s_data_i;
    bus.gnt_o    = gnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ptr_q        <= IDXW'(MASTERCOUNT - 1);
      gnt_q        <= '0;
      burst_left_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q      <= ST_GRANT;
            idx_q        <= pick_idx;
            gnt_q        <= GNT_ONE << pick_idx;
            burst_left_q <= BURST_LD;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            burst_left_q <= burst_left_q - 8'd1;
            if (burst_left_q == 8'd1) state_q <= ST_DRAIN;
          end else if (bus.s_rdy_i) begin
            // Owner went idle: this rdy already delivered any pending read.
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.s_rdy_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= idx_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pi1r_rrarb.sv
// Directed and random checks of pi1r_rrarb against a behavioural ownership model.
module tb_pi1r_rrarb;
  localparam int AW  = 32;
  localparam int MC  = 4;
  localparam int BM  = 8;
  localparam int ADW = 30;
  localparam int SW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pi1r_rrarb_if #(.ARCHBITSZ(AW), .MASTERCOUNT(MC)) bus ();
  pi1r_rrarb #(.ARCHBITSZ(AW), .MASTERCOUNT(MC), .BURSTMAX(BM)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus)
  );

  logic [1:0]     op_a   [MC];
  logic [ADW-1:0] addr_a [MC];
  logic [AW-1:0]  wdat_a [MC];
  logic [SW-1:0]  sel_a  [MC];
  logic           srdy;
  logic [AW-1:0]  sdat;

  int errors = 0;
  int checks = 0;

  // Model: who owns the port, whether it is draining, accepts this tenure, last owner.
  int owner, ptr, acc, acc_who;
  bit draining;

  int grant_q[$];
  int accq[$];
  logic [MC-1:0] prev_gnt;
  int tenure_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < MC; i++) begin
      bus.m_op_i[2*i +: 2]       = op_a[i];
      bus.m_addr_i[ADW*i +: ADW] = addr_a[i];
      bus.m_data_i[AW*i +: AW]   = wdat_a[i];
      bus.m_sel_i[SW*i +: SW]    = sel_a[i];
    end
    bus.s_rdy_i  = srdy;
    bus.s_data_i = sdat;
  endtask

  task automatic model_update();
    bit found;
    int j;
    acc_who = -1;
    if (!rst_n) begin
      owner = -1; draining = 0; ptr = MC - 1; acc = 0;
    end else if (owner < 0) begin
      found = 0;
      for (int k = 1; k <= MC; k++) begin
        j = (ptr + k) % MC;
        if (!found && op_a[j] != 2'd0) begin
          found = 1; owner = j; acc = 0;
        end
      end
    end else if (!draining) begin
      if (srdy && op_a[owner] != 2'd0) begin
        acc++; acc_who = owner;
        if (acc == BM) draining = 1;
      end else if (srdy) begin
        draining = 1;
      end
    end else if (srdy) begin
      ptr = owner; owner = -1; draining = 0;
    end
  endtask

  task automatic cycle();
    logic [MC-1:0] eg, er;
    logic [1:0] eop;
    logic [ADW+AW+SW-1:0] ebus;
    apply();
    @(negedge clk);
    eg   = (owner >= 0) ? (MC'(1) << owner) : '0;
    er   = srdy ? eg : '0;
    eop  = (owner >= 0 && !draining) ? op_a[owner] : 2'd0;
    ebus = (owner >= 0) ? {addr_a[owner], wdat_a[owner], sel_a[owner]} : '0;
    chk("gnt", bus.gnt_o, eg);
    chk("m_rdy", bus.m_rdy_o, er);
    chk("s_op", bus.s_op_o, eop);
    chk("s_bus", {bus.s_addr_o, bus.s_data_o, bus.s_sel_o}, ebus);
    chk("m_data", bus.m_data_o, sdat);
    chk("rdy_onehot0", $onehot0(bus.m_rdy_o), 1'b1);
    if (prev_gnt != 0 && bus.gnt_o == 0) begin
      accq.push_back(tenure_acc);
      tenure_acc = 0;
    end
    if (prev_gnt == 0 && bus.gnt_o != 0) grant_q.push_back($clog2(bus.gnt_o));
    if (bus.gnt_o != 0 && bus.s_op_o != 2'd0 && srdy) tenure_acc++;
    prev_gnt = bus.gnt_o;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic all_ops(input logic [1:0] op);
    for (int i = 0; i < MC; i++) op_a[i] = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    grant_q.delete();
    accq.delete();
    prev_gnt = '0;
    tenure_acc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < MC; i++) begin
      addr_a[i] = ADW'(32'h100 * (i + 1));
      wdat_a[i] = 32'hA000_0000 + i;
      sel_a[i]  = SW'(4'hF - i);
    end
    all_ops(2'd2);
    srdy = 1'b0; sdat = '0; rst_n = 1'b0;
    prev_gnt = '0; tenure_acc = 0;
    apply();
    @(posedge clk); #1;
    owner = -1; draining = 0; ptr = MC - 1; acc = 0; acc_who = -1;

    // Reset held with every requester reading.
    for (int c = 0; c < 3; c++) cycle();
    chk("t1_gnt", bus.gnt_o, 4'b0000);
    chk("t1_rdy", bus.m_rdy_o, 4'b0000);
    chk("t1_sop", bus.s_op_o, 2'd0);

    // Single read by m0.
    rst_n = 1'b1;
    all_ops(2'd0);
    op_a[0] = 2'd2; addr_a[0] = ADW'(32'h400); srdy = 1'b1; sdat = 32'hDEADBEEF;
    cycle();
    chk("t2_gnt", bus.gnt_o, 4'b0001);
    cycle();
    op_a[0] = 2'd0;
    apply(); #1;
    chk("t2_rdy", bus.m_rdy_o, 4'b0001);
    chk("t2_rdata", bus.m_data_o, 32'hDEADBEEF);
    cycle();
    cycle();
    chk("t2_idle", bus.gnt_o, 4'b0000);

    // Round robin with everyone writing continuously.
    do_reset();
    all_ops(2'd1); srdy = 1'b1;
    for (int c = 0; c < 45; c++) cycle();
    chk("t3_ngrants", grant_q.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_order%0d", i), (i < grant_q.size()) ? grant_q[i] : -1, i % MC);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_accepts%0d", i), (i < accq.size()) ? accq[i] : -1, BM);

    // Backpressure on a read by m2.
    do_reset();
    all_ops(2'd0);
    op_a[2] = 2'd2; addr_a[2] = ADW'(32'h2468); srdy = 1'b0; sdat = 32'hCAFEF00D;
    cycle();
    for (int c = 0; c < 5; c++) cycle();
    chk("t4_hold_op", bus.s_op_o, 2'd2);
    chk("t4_hold_gnt", bus.gnt_o, 4'b0100);
    srdy = 1'b1;
    cycle();
    chk("t4_after_acc", bus.gnt_o, 4'b0100);
    op_a[2] = 2'd0; sdat = 32'h1234_5678;
    apply(); #1;
    chk("t4_rdata", bus.m_data_o, 32'h1234_5678);
    chk("t4_rdy", bus.m_rdy_o, 4'b0100);
    cycle();
    cycle();
    chk("t4_released", bus.gnt_o, 4'b0000);

    // Fairness: m3 arrives while m1 is mid-burst.
    do_reset();
    all_ops(2'd0);
    op_a[1] = 2'd1; srdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) op_a[3] = 2'd1;
      cycle();
      if (acc_who == 3) op_a[3] = 2'd0;
    end
    chk("t5_ngrants", grant_q.size() >= 3, 1'b1);
    chk("t5_first", (grant_q.size() > 0) ? grant_q[0] : -1, 1);
    chk("t5_second", (grant_q.size() > 1) ? grant_q[1] : -1, 3);
    chk("t5_third", (grant_q.size() > 2) ? grant_q[2] : -1, 1);
    chk("t5_m1_burst", (accq.size() > 0) ? accq[0] : -1, BM);

    // Reset while draining with a read outstanding.
    do_reset();
    all_ops(2'd0);
    op_a[0] = 2'd2; srdy = 1'b1;
    for (int c = 0; c < 9; c++) cycle();
    srdy = 1'b0;
    cycle();
    chk("t6_drain_gnt", bus.gnt_o, 4'b0001);
    chk("t6_drain_op", bus.s_op_o, 2'd0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_gnt", bus.gnt_o, 4'b0000);
    all_ops(2'd1); srdy = 1'b1;
    cycle();
    chk("t6_ptr", bus.gnt_o, 4'b0001);

    // Random traffic, random backpressure, occasional reset.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < MC; i++) begin
        if ($urandom_range(0, 3) == 0) op_a[i] = 2'($urandom_range(0, 3));
        addr_a[i] = ADW'($urandom);
        wdat_a[i] = $urandom;
        sel_a[i]  = SW'($urandom);
      end
      srdy  = ($urandom_range(0, 3) != 0);
      sdat  = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
